// File: rtl/sum_frame_accumulator.sv
// sum_frame_accumulator: gathers FRAME_LEN adder SUM samples into one ACC_W-bit
// frame total. Each total is presented on a held valid/ready output with an
// overflow flag, and a free-running delivered-frame counter is kept alongside.
// Optional feature macro: SUM_FRAME_ACC_SAT_EN makes the accumulator saturate
// at 2^ACC_W-1 on overflow. When it is undefined, the accumulator wraps.
module sum_frame_accumulator #(
  parameter int unsigned FRAME_LEN = 4,
  parameter int unsigned ACC_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       sum_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_total,
  output logic             out_ovf,
  output logic [7:0]       frame_cnt
);

  localparam int unsigned    CW   = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [CW-1:0]  LAST = CW'(FRAME_LEN - 1);

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t           state, state_nxt;
  logic [ACC_W-1:0] acc;
  logic [CW-1:0]    cnt;
  logic             ovf;
  logic             in_fire, out_fire, last;
  logic [ACC_W:0]   add_full;
  logic             add_carry;
  logic [ACC_W-1:0] acc_nxt;

  // clr suppresses both handshakes in the cycle it is asserted
  assign in_fire  = in_valid  && (state == ACCUM) && !clr;
  assign out_fire = out_ready && (state == HOLD)  && !clr;
  assign last     = (cnt == LAST);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ACCUM;
    else     state <= state_nxt;
  end

  // Next-state and handshake outputs
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      ACCUM: begin
        in_ready = 1'b1;
        if (in_fire && last) state_nxt = HOLD;
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_fire) state_nxt = ACCUM;
      end
      default: state_nxt = ACCUM;
    endcase
    if (clr) state_nxt = ACCUM;
  end

  // Widened add: the carry out of the top bit flags overflow
  always_comb begin
    add_full  = {1'b0, acc} + {{(ACC_W-2){1'b0}}, sum_in};
    add_carry = add_full[ACC_W];
`ifdef SUM_FRAME_ACC_SAT_EN
    acc_nxt   = add_carry ? '1 : add_full[ACC_W-1:0];
`else
    acc_nxt   = add_full[ACC_W-1:0];
`endif
  end

  // Accumulator, sample count, sticky overflow and the held result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      out_total <= '0;
      out_ovf   <= 1'b0;
    end else if (clr) begin
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else if (in_fire) begin
      if (last) begin
        out_total <= acc_nxt;
        out_ovf   <= ovf | add_carry;
        acc       <= '0;
        cnt       <= '0;
        ovf       <= 1'b0;
      end else begin
        acc <= acc_nxt;
        cnt <= cnt + CW'(1);
        ovf <= ovf | add_carry;
      end
    end
  end

  // Delivered-frame counter; survives clr, wraps naturally at 8 bits
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           frame_cnt <= '0;
    else if (out_fire) frame_cnt <= frame_cnt + 8'd1;
  end

endmodule

// File: tb/tb_sum_frame_accumulator.sv
module tb_sum_frame_accumulator;

  typedef struct {
    int total;
    bit ovf;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  // default instance: FRAME_LEN=4, ACC_W=8
  logic       clr0 = 1'b0, in_valid0 = 1'b0, out_ready0 = 1'b0;
  logic [2:0] sum0 = '0;
  logic       in_ready0, out_valid0, out_ovf0;
  logic [7:0] out_total0, frame_cnt0;

  // narrow instance: FRAME_LEN=4, ACC_W=4
  logic       clr4 = 1'b0, in_valid4 = 1'b0, out_ready4 = 1'b0;
  logic [2:0] sum4 = '0;
  logic       in_ready4, out_valid4, out_ovf4;
  logic [3:0] out_total4;
  logic [7:0] frame_cnt4;

  // single-sample instance: FRAME_LEN=1, ACC_W=8
  logic       clr1 = 1'b0, in_valid1 = 1'b0, out_ready1 = 1'b0;
  logic [2:0] sum1 = '0;
  logic       in_ready1, out_valid1, out_ovf1;
  logic [7:0] out_total1, frame_cnt1;

  int   total = 0;
  int   bad   = 0;
  exp_t q0[$];
  exp_t q4[$];
  int   m_acc = 0;
  bit   m_ovf = 0;
  int   m_n   = 0;
  int   fc0   = 0;

  always #5 clk = ~clk;

  sum_frame_accumulator u0 (
    .clk(clk), .rst(rst), .clr(clr0), .in_valid(in_valid0), .in_ready(in_ready0),
    .sum_in(sum0), .out_valid(out_valid0), .out_ready(out_ready0),
    .out_total(out_total0), .out_ovf(out_ovf0), .frame_cnt(frame_cnt0)
  );

  sum_frame_accumulator #(.FRAME_LEN(4), .ACC_W(4)) u4 (
    .clk(clk), .rst(rst), .clr(clr4), .in_valid(in_valid4), .in_ready(in_ready4),
    .sum_in(sum4), .out_valid(out_valid4), .out_ready(out_ready4),
    .out_total(out_total4), .out_ovf(out_ovf4), .frame_cnt(frame_cnt4)
  );

  sum_frame_accumulator #(.FRAME_LEN(1), .ACC_W(8)) u1 (
    .clk(clk), .rst(rst), .clr(clr1), .in_valid(in_valid1), .in_ready(in_ready1),
    .sum_in(sum1), .out_valid(out_valid1), .out_ready(out_ready1),
    .out_total(out_total1), .out_ovf(out_ovf1), .frame_cnt(frame_cnt1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // reference add: plain integer arithmetic against the 2^w limit
  function automatic void model_add(inout int acc, inout bit ovf, input int s, input int w);
    int lim;
    lim = (1 << w) - 1;
    if (acc + s > lim) begin
      ovf = 1'b1;
`ifdef SUM_FRAME_ACC_SAT_EN
      acc = lim;
`else
      acc = acc + s - (lim + 1);
`endif
    end else begin
      acc = acc + s;
    end
  endfunction

  // present one sample to u0, wait (bounded) until it is taken, update the model
  task automatic put0(input int s);
    int n;
    n = 0;
    @(negedge clk);
    in_valid0 = 1'b1;
    sum0      = 3'(s);
    while (!in_ready0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("accept_wait", in_ready0, 1);
    @(posedge clk);
    #1;
    in_valid0 = 1'b0;
    model_add(m_acc, m_ovf, s, 8);
    m_n++;
    if (m_n == 4) begin
      q0.push_back('{m_acc, m_ovf});
      m_acc = 0;
      m_ovf = 1'b0;
      m_n   = 0;
    end
  endtask

  // called at a negedge with out_ready0=1: wait for a result, compare with scoreboard
  task automatic get0(input string tag, output int lat);
    exp_t e;
    lat = 0;
    while (!out_valid0 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_valid"}, out_valid0, 1);
    chk({tag, "_sb_nonempty"}, q0.size() > 0, 1);
    if (q0.size() > 0) begin
      e = q0.pop_front();
      chk({tag, "_total"}, out_total0, e.total);
      chk({tag, "_ovf"}, out_ovf0, e.ovf);
    end
    fc0++;
  endtask

  initial begin
    int   lat;
    int   n;
    int   a4;
    bit   o4;
    exp_t e;
    int   frames4 [2][4];
    frames4 = '{'{6, 6, 6, 6}, '{1, 2, 3, 4}};

    // reset values
    @(negedge clk);
    chk("rst_in_ready", in_ready0, 1);
    chk("rst_out_valid", out_valid0, 0);
    chk("rst_out_total", out_total0, 0);
    chk("rst_out_ovf", out_ovf0, 0);
    chk("rst_frame_cnt", frame_cnt0, 0);
    rst = 1'b0;

    // back-to-back frame with out_ready high; result one cycle after last accept
    out_ready0 = 1'b1;
    put0(0); put0(2); put0(4); put0(3);
    @(negedge clk);
    chk("t1_fc_before", frame_cnt0, fc0);
    get0("t1", lat);
    chk("t1_latency", lat, 0);
    @(negedge clk);
    chk("t1_valid_drop", out_valid0, 0);
    chk("t1_fc_after", frame_cnt0, fc0);
    chk("t1_in_ready", in_ready0, 1);

    // backpressure: result held, next frame refused until release
    out_ready0 = 1'b0;
    put0(5); put0(5); put0(5); put0(5);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid0 = 1'b1;
      sum0      = 3'd1;
      chk("t2_in_ready_low", in_ready0, 0);
      chk("t2_valid_held", out_valid0, 1);
      chk("t2_total_stable", out_total0, q0[0].total);
    end
    out_ready0 = 1'b1;
    get0("t2a", lat);
    put0(1); put0(1); put0(1); put0(1);
    @(negedge clk);
    get0("t2b", lat);
    @(negedge clk);
    chk("t2_fc", frame_cnt0, fc0);

    // clr while a result is held and out_ready is high: result dropped
    out_ready0 = 1'b0;
    put0(2); put0(2); put0(2); put0(2);
    @(negedge clk);
    clr0       = 1'b1;
    out_ready0 = 1'b1;
    @(negedge clk);
    clr0       = 1'b0;
    void'(q0.pop_back());
    chk("t4h_valid", out_valid0, 0);
    chk("t4h_in_ready", in_ready0, 1);
    chk("t4h_fc", frame_cnt0, fc0);

    // clr after two samples, with a sample presented in the clr cycle
    put0(5); put0(5);
    @(negedge clk);
    clr0      = 1'b1;
    in_valid0 = 1'b1;
    sum0      = 3'd7;
    @(negedge clk);
    clr0      = 1'b0;
    in_valid0 = 1'b0;
    m_acc = 0; m_ovf = 1'b0; m_n = 0;
    chk("t4_fc_after_clr", frame_cnt0, fc0);
    put0(1); put0(1); put0(1); put0(1);
    @(negedge clk);
    get0("t4", lat);
    @(negedge clk);
    chk("t4_fc", frame_cnt0, fc0);

    // async reset while holding a result
    out_ready0 = 1'b0;
    put0(0); put0(2); put0(4); put0(3);
    @(negedge clk);
    chk("t5_valid", out_valid0, 1);
    chk("t5_total", out_total0, q0[0].total);
    #2;
    rst = 1'b1;
    #1;
    chk("t5_rst_valid", out_valid0, 0);
    chk("t5_rst_total", out_total0, 0);
    chk("t5_rst_ovf", out_ovf0, 0);
    chk("t5_rst_fc", frame_cnt0, 0);
    chk("t5_rst_in_ready", in_ready0, 1);
    q0.delete();
    fc0 = 0;
    @(negedge clk);
    rst = 1'b0;

    // narrow accumulator: overflow frame, then a clean frame (ovf must not linger)
    out_ready4 = 1'b1;
    for (int f = 0; f < 2; f++) begin
      a4 = 0;
      o4 = 1'b0;
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        in_valid4 = 1'b1;
        sum4      = 3'(frames4[f][i]);
        model_add(a4, o4, frames4[f][i], 4);
      end
      q4.push_back('{a4, o4});
      @(negedge clk);
      in_valid4 = 1'b0;
      n = 0;
      while (!out_valid4 && n < 20) begin
        @(negedge clk);
        n++;
      end
      chk("t3_valid", out_valid4, 1);
      e = q4.pop_front();
      chk("t3_total", out_total4, e.total);
      chk("t3_ovf", out_ovf4, e.ovf);
    end

    // FRAME_LEN=1: alternating accept/emit, frame counter wraps after 256 frames
    out_ready1 = 1'b1;
    @(negedge clk);
    in_valid1 = 1'b1;
    sum1      = 3'd7;
    for (int i = 1; i <= 513; i++) begin
      @(negedge clk);
      chk("t6_valid", out_valid1, i % 2);
      chk("t6_in_ready", in_ready1, 1 - (i % 2));
      chk("t6_fc", frame_cnt1, (i / 2) % 256);
      if (i % 2 == 1) begin
        chk("t6_total", out_total1, 7);
        chk("t6_ovf", out_ovf1, 0);
      end
    end
    in_valid1 = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
